// File: rtl/cr_prefix_attach_pfx_rd.sv
// Prefix-memory read sequencer: streams N_WORDS words to the TLV formatter and signals eot with CRC-32.
// Optional byte-parity checking is built when CR_PREFIX_PFX_RD_PARITY_EN is defined.
module cr_prefix_attach_pfx_rd #(
  parameter int unsigned N_WORDS = 8,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_dout,
`ifdef CR_PREFIX_PFX_RD_PARITY_EN
  input  logic [7:0]        mem_par,
  output logic              par_err,
`endif
  output logic              dout_valid,
  output logic [63:0]       dout,
  output logic              eot,
  output logic [31:0]       crc,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StCrc} state_e;

  localparam int unsigned   CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N_WORDS - 1);
  localparam logic [31:0]   CrcInit = 32'hFFFF_FFFF;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [63:0]         dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic [31:0]         crc_q, crc_d;
  logic [31:0]         crc_out_q, crc_out_d;

  // Reflected CRC-32, LSB of the word first, which is byte 0 first.
  function automatic logic [31:0] crc32_upd64(input logic [31:0] c_in, input logic [63:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 64; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

`ifdef CR_PREFIX_PFX_RD_PARITY_EN
  logic [7:0] byte_par;
  logic       par_err_q, par_err_d;

  always_comb begin
    byte_par = '0;
    for (int b = 0; b < 8; b++) byte_par[b] = ^mem_dout[8*b +: 8];
  end
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    crc_out_d    = crc_out_q;
    dout_valid_d = vld_q[RD_LAT-1];
    dout_d       = vld_q[RD_LAT-1] ? mem_dout : dout_q;
    vld_d[0]     = (state_q == StIssue);
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
`ifdef CR_PREFIX_PFX_RD_PARITY_EN
    par_err_d = par_err_q;
    if (vld_q[RD_LAT-1] && (byte_par != mem_par)) par_err_d = 1'b1;
`endif

    if (dout_valid_q) crc_d = crc32_upd64(crc_q, dout_q);

    if (abort) begin
      // Flush the read pipeline; crc output and sticky flags are left alone.
      state_d      = StIdle;
      vld_d        = '0;
      dout_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StIssue;
            addr_d  = base_addr;
            cnt_d   = '0;
            crc_d   = CrcInit;
`ifdef CR_PREFIX_PFX_RD_PARITY_EN
            par_err_d = 1'b0;
`endif
          end
        end
        StIssue: begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StDrain;
        end
        StDrain: begin
          // The last word may still be in dout this cycle; crc_d already includes it.
          if (vld_q == '0) begin
            state_d   = StCrc;
            crc_out_d = ~crc_d;
`ifdef CR_PREFIX_PFX_RD_PARITY_EN
            if (par_err_q) crc_out_d = crc_d;
`endif
          end
        end
        StCrc: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      cnt_q        <= '0;
      vld_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      crc_q        <= CrcInit;
      crc_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      vld_q        <= vld_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      crc_q        <= crc_d;
      crc_out_q    <= crc_out_d;
    end
  end

`ifdef CR_PREFIX_PFX_RD_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

  assign mem_rd     = (state_q == StIssue);
  assign mem_addr   = addr_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign eot        = (state_q == StCrc);
  assign crc        = crc_out_q;
  assign busy       = (state_q != StIdle);

endmodule
